// File: rtl/gf16_inv_gen_if.sv
// Handshake bundle between the polynomial divider (initiator) and the GF(2^16) inverter.
// Vectors are [0:15] so that index i is the coefficient of x^i.
interface gf16_inv_gen_if;
    logic [0:15] inv_out;
    logic        inv_en;
    logic        inv_trg;
    logic [0:15] inv_r_dat;
    logic        inv_busy;
    logic        inv_done;

    modport master (
        output inv_out, inv_en, inv_trg,
        input  inv_r_dat, inv_busy, inv_done
    );

    modport slave (
        input  inv_out, inv_en, inv_trg,
        output inv_r_dat, inv_busy, inv_done
    );
endinterface

// File: rtl/gf16_inv_gen.sv
// GF(2^16) inversion responder: a^-1 = a^(2^16-2) as the product of a^(2^i), i=1..15,
// accumulated one factor per cycle; the result is published 15 edges after the trigger.
module gf16_inv_gen #(
    parameter logic [15:0] POLY = 16'h002B
) (
    input  logic           clk,
    input  logic           rst_b,
    gf16_inv_gen_if.slave  inv_if
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t      state, state_n;
    logic [15:0] s, s_n;
    logic [15:0] r, r_n;
    logic [15:0] res, res_n;
    logic [3:0]  cnt, cnt_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic [15:0] a_le;
    logic [15:0] a_sq;
    logic [15:0] s_sq;
    logic        accept;

    // Squaring spreads the bits to even positions, then folds x^16 and above back with POLY.
    function automatic logic [15:0] gf_sq(input logic [15:0] v);
        logic [30:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            t[2*i] = v[i];
        end
        for (int k = 30; k >= 16; k--) begin
            if (t[k]) begin
                t = t ^ (31'({1'b1, POLY}) << (k - 16));
            end
        end
        return t[15:0];
    endfunction

    function automatic logic [15:0] gf_mul(input logic [15:0] u, input logic [15:0] v);
        logic [15:0] p;
        p = '0;
        for (int i = 15; i >= 0; i--) begin
            p = {p[14:0], 1'b0} ^ (p[15] ? POLY : 16'h0000);
            if (v[i]) begin
                p = p ^ u;
            end
        end
        return p;
    endfunction

    always_comb begin
        a_le = '0;
        inv_if.inv_r_dat = '0;
        for (int i = 0; i < 16; i++) begin
            a_le[i]             = inv_if.inv_out[i];
            inv_if.inv_r_dat[i] = res[i];
        end
    end

    assign inv_if.inv_busy = busy;
    assign inv_if.inv_done = done;
    assign accept = inv_if.inv_en & inv_if.inv_trg;
    assign a_sq   = gf_sq(a_le);
    assign s_sq   = gf_sq(s);

    // A trigger in any state (re)loads the operand, so a retrigger silently abandons a job in flight.
    always_comb begin
        state_n = state;
        s_n     = s;
        r_n     = r;
        cnt_n   = cnt;
        res_n   = res;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
            end
            CALC: begin
                s_n   = s_sq;
                r_n   = gf_mul(r, s_sq);
                cnt_n = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                res_n   = r;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (accept) begin
            s_n     = a_sq;
            r_n     = a_sq;
            cnt_n   = 4'd2;
            busy_n  = 1'b1;
            state_n = CALC;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            s     <= '0;
            r     <= '0;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            s     <= s_n;
            r     <= r_n;
            cnt   <= cnt_n;
            res   <= res_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_gf16_inv_gen.sv
// Scoreboard bench for gf16_inv_gen: the driver queues expected results computed by
// plain field exponentiation; the monitor pops and compares whenever inv_done pulses.
module tb_gf16_inv_gen;

    localparam logic [15:0] POLY = 16'h002B;

    typedef struct {
        logic [15:0] a;
        logic [15:0] exp;
        int          due;
    } job_t;

    logic clk;
    logic rst_b;
    int   cyc;
    int   checks;
    int   passes;
    job_t exp_q[$];
    logic [15:0] last_dat;

    gf16_inv_gen_if bus();

    gf16_inv_gen #(.POLY(POLY)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .inv_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Schoolbook polynomial product, then reduction modulo x^16 + POLY.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] prod;
        logic [31:0] full;
        prod = 32'h0;
        full = {15'h0, 1'b1, POLY};
        for (int i = 0; i < 16; i++) begin
            if (b[i]) prod = prod ^ ({16'h0, a} << i);
        end
        for (int k = 31; k >= 16; k--) begin
            if (prod[k]) prod = prod ^ (full << (k - 16));
        end
        return prod[15:0];
    endfunction

    function automatic logic [15:0] ref_inv(input logic [15:0] a);
        logic [15:0] result;
        logic [15:0] base;
        int          e;
        result = 16'h0001;
        base   = a;
        e      = 65534;
        while (e != 0) begin
            if (e % 2 == 1) result = ref_mul(result, base);
            base = ref_mul(base, base);
            e    = e / 2;
        end
        return result;
    endfunction

    function automatic logic [15:0] from_bus(input logic [0:15] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [0:15] to_bus(input logic [15:0] v);
        logic [0:15] r;
        for (int i = 0; i < 16; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Called just after a rising edge; the trigger is sampled on the following edge (E0).
    task automatic apply_stimulus(input logic [15:0] a, input logic en);
        job_t j;
        bus.inv_out = to_bus(a);
        bus.inv_en  = en;
        bus.inv_trg = 1'b1;
        @(posedge clk);
        #1;
        bus.inv_trg = 1'b0;
        bus.inv_out = to_bus(16'($urandom));
        if (en) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            j.a   = a;
            j.exp = ref_inv(a);
            j.due = cyc + 15;
            exp_q.push_back(j);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_int("done_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check_output("reset_dat", from_bus(bus.inv_r_dat), 16'h0000);
        check_output("reset_busy", {15'h0, bus.inv_busy}, 16'h0000);
        check_output("reset_done", {15'h0, bus.inv_done}, 16'h0000);
    endtask

    always @(negedge clk) begin
        logic [15:0] cur;
        job_t        e;
        if (!rst_b) begin
            last_dat = 16'h0000;
        end else begin
            cur = from_bus(bus.inv_r_dat);
            if (bus.inv_done) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_done", {15'h0, bus.inv_done}, 16'h0000);
                end else begin
                    e = exp_q.pop_front();
                    check_output("result", cur, e.exp);
                    check_int("latency", cyc, e.due);
                    check_output("busy_at_done", {15'h0, bus.inv_busy}, 16'h0000);
                end
                last_dat = cur;
            end else begin
                check_output("hold", cur, last_dat);
                check_output("busy", {15'h0, bus.inv_busy}, {15'h0, exp_q.size() > 0});
            end
        end
    end

    initial begin
        logic [15:0] a;
        rst_b       = 1'b0;
        last_dat    = 16'h0000;
        checks      = 0;
        passes      = 0;
        bus.inv_out = '0;
        bus.inv_en  = 1'b0;
        bus.inv_trg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Directed operands: identity, x, and zero.
        apply_stimulus(16'h0001, 1'b1);
        wait_idle();
        check_output("inv_one", from_bus(bus.inv_r_dat), 16'h0001);
        apply_stimulus(16'h0002, 1'b1);
        wait_idle();
        check_output("inv_x", from_bus(bus.inv_r_dat), 16'h8015);
        apply_stimulus(16'h0000, 1'b1);
        wait_idle();
        check_output("inv_zero", from_bus(bus.inv_r_dat), 16'h0000);

        // Retrigger at E7: the job for x is abandoned, only the identity result appears.
        apply_stimulus(16'h0002, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        apply_stimulus(16'h0001, 1'b1);
        wait_idle();
        check_output("retrigger", from_bus(bus.inv_r_dat), 16'h0001);

        // Trigger with the enable low must be ignored entirely.
        apply_stimulus(16'h1234, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_output("en_low_dat", from_bus(bus.inv_r_dat), 16'h0001);

        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(1, 65535));
            apply_stimulus(a, 1'b1);
            wait_idle();
            if (i % 100 == 0) begin
                check_output("random_inverse", ref_mul(a, from_bus(bus.inv_r_dat)), ref_mul(a, ref_inv(a)));
            end
        end

        // Asynchronous reset at E9 of a job, then a fresh job with normal latency.
        apply_stimulus(16'h0002, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(16'h0002, 1'b1);
        wait_idle();
        check_output("after_reset", from_bus(bus.inv_r_dat), 16'h8015);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gf16_inv_gen.md
Name: gf16_inv_gen

Overview:
- GF(2^16) inversion responder serving the polynomial divider's INV_GENERATOR port.
- Accepts an operand and a one-cycle trigger from the initiator, computes a^-1 = a^(2^16-2) by iterative square-and-multiply, and returns the result on a held output register.
- Fixed latency of 15 cycles, well inside the divider's 28-cycle sampling window.

Parameters:
- POLY, 16'h002B, low 16 coefficients of the field polynomial x^16+x^5+x^3+x+1. Bit i is the coefficient of x^i.

Ports:
- clk  input  1  clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- inv_out  input  [0:15]  operand from initiator; bit i = coefficient of x^i
- inv_en  input  1  level enable; the block accepts triggers only while high
- inv_trg  input  1  one-cycle start pulse
- inv_r_dat  output  [0:15]  inverse result, registered, bit i = coefficient of x^i
- inv_busy  output  1  high while a computation is in flight
- inv_done  output  1  one-cycle pulse when inv_r_dat updates

Behaviour:
- Clocking and reset: one clock, clk; reset rst_b is asynchronous, active-low.
- Reset values: inv_r_dat=0, inv_busy=0, inv_done=0, state=IDLE, cnt=0, internal s/r=0.
- Hex notation in this spec: value = sum of bit[i]·2^i.
- Combinational helpers:
  - sq(v): GF squaring reduced by POLY.
  - mul(u,v): GF multiply reduced by POLY.
  - Both are pure functions of their inputs within one cycle.
- States: IDLE, CALC, FINISH.
- IDLE:
  - Accept condition: inv_en=1 and inv_trg=1 at edge E0.
  - On accept: s<=sq(inv_out), r<=sq(inv_out), cnt<=2, inv_busy<=1, go to CALC.
  - If inv_en=0, inv_trg is ignored.
- CALC (edges E1..E14):
  - Each edge: s<=sq(s); r<=mul(r,sq(s)); cnt<=cnt+1.
  - When cnt==15 at the edge, go to FINISH.
  - After E14, r holds the product of a^(2^i) for i=1..15, i.e. a^-1.
- FINISH (edge E15):
  - inv_r_dat<=r, inv_done<=1 for exactly one cycle, inv_busy<=0, go to IDLE.
  - inv_r_dat is valid from E15 and held until the next FINISH, regardless of inv_en.
- Latency: the result is visible 15 edges after the trigger is sampled. inv_done is high during the cycle after E15.
- Zero operand: a=0 yields 0 naturally, with no special path. Timing is identical.
- Retrigger while busy (inv_en=1, inv_trg=1 in CALC): abort the current computation and restart as from IDLE with the new operand. inv_r_dat is not updated by the aborted job, and no inv_done is produced for it.
- inv_en deasserted mid-computation: the computation completes normally. inv_en gates only trigger acceptance.
- inv_trg held high for multiple cycles: every sampled high while inv_en=1 (re)starts, so the last sample wins. The initiator must pulse for one cycle.
- Reset mid-operation: immediate return to reset values. The partial result is discarded and inv_r_dat is cleared to 0.
- inv_out is sampled only at the accept edge. Changes afterwards have no effect.

Test Plan:
- Reset, then inv_en=1 and a one-cycle trg with inv_out=16'h0001 -> inv_busy high E0..E14, inv_done pulse after E15, inv_r_dat=16'h0001.
- inv_out=16'h0002 (x) -> inv_r_dat=16'h8015 (x^15+x^4+x^2+1) exactly 15 edges after trigger.
- inv_out=16'h0000 -> inv_r_dat=16'h0000, same 15-cycle timing, inv_done pulses once.
- 1000 random nonzero operands, back-to-back triggers issued after each inv_done -> reference model checks mul(a,inv_r_dat)==16'h0001 every time; inv_r_dat stable between pulses.
- Trigger with a=16'h0002, retrigger at E7 with a=16'h0001:
  - Expected: single inv_done 15 edges after the second trigger, inv_r_dat=16'h0001, no intermediate 16'h8015.
  - Separately, trigger with inv_en=0: no busy, no done, output unchanged.
- Assert rst_b low at E9 of a job -> outputs 0 immediately and asynchronously. After release, a new trigger with a=16'h0002 returns 16'h8015 with normal latency.
